// File: rtl/wr_rd_ptr_sync_status.sv
// Write-domain receiver for the Gray read pointer: synchronizer, fill level, almost-full and sticky errors.
// Optional high-water mark on wr_peak is enabled by defining WR_STATUS_PEAK_EN.
module wr_rd_ptr_sync_status #(
  parameter int ADDR_WIDTH  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 60
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  wr_en,
  input  logic                  full,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   rd_sync_to_wr,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  almost_full,
  output logic                  level_valid,
  output logic                  overflow_err,
  output logic                  ptr_err,
  output logic [ADDR_WIDTH:0]   wr_peak
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AF_T     = AF_THRESH[PW-1:0];
  localparam logic [2:0]    FLUSH_TC = 3'(SYNC_STAGES);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_level;
  logic          r_almost_full;
  logic [2:0]    r_flush_cnt;
  logic          r_level_valid;
  logic          r_overflow_err;
  logic          r_ptr_err;

  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_next_level;
  logic          w_ovf_set;
  logic          w_ptr_set;

  // Plain flop chain: rd_ptr is Gray coded so only one bit moves per change.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= rd_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign rd_sync_to_wr = r_sync[SYNC_STAGES-1];

  assign w_rd_bin     = gray2bin(rd_sync_to_wr);
  assign w_wr_bin     = gray2bin(wr_ptr);
  assign w_next_level = w_wr_bin - w_rd_bin;

  assign w_ovf_set = wr_en && full;
  assign w_ptr_set = r_level_valid && (w_next_level > DEPTH_V);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_next_level;
      r_almost_full <= (w_next_level >= AF_T);
    end
  end

  // Flush counter saturates at SYNC_STAGES; valid rises one edge later and then holds.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_flush_cnt   <= '0;
      r_level_valid <= 1'b0;
    end else begin
      if (r_flush_cnt != FLUSH_TC) r_flush_cnt <= r_flush_cnt + 3'd1;
      if (r_flush_cnt == FLUSH_TC) r_level_valid <= 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_overflow_err <= 1'b0;
      r_ptr_err      <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow_err <= 1'b1;
      else if (err_clr) r_overflow_err <= 1'b0;
      if (w_ptr_set)    r_ptr_err <= 1'b1;
      else if (err_clr) r_ptr_err <= 1'b0;
    end
  end

  assign wr_level     = r_level;
  assign almost_full  = r_almost_full;
  assign level_valid  = r_level_valid;
  assign overflow_err = r_overflow_err;
  assign ptr_err      = r_ptr_err;

`ifdef WR_STATUS_PEAK_EN
  logic [PW-1:0] r_peak;

  // Clear has priority over a simultaneous update.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_peak <= '0;
    end else if (err_clr) begin
      r_peak <= '0;
    end else if (r_level_valid && (w_next_level > r_peak)) begin
      r_peak <= w_next_level;
    end
  end

  assign wr_peak = r_peak;
`else
  assign wr_peak = '0;
`endif

endmodule

// File: tb/tb_wr_rd_ptr_sync_status.sv
// Directed bench for wr_rd_ptr_sync_status with hand-computed expectations.
// Checks wr_peak behaviour when WR_STATUS_PEAK_EN is defined, otherwise checks it is tied low.
module tb_wr_rd_ptr_sync_status;

  logic       wr_clk = 1'b0;
  logic       wr_rst_n;
  logic [6:0] rd_ptr;
  logic [6:0] wr_ptr;
  logic       wr_en;
  logic       full;
  logic       err_clr;
  logic [6:0] rd_sync_to_wr;
  logic [6:0] wr_level;
  logic       almost_full;
  logic       level_valid;
  logic       overflow_err;
  logic       ptr_err;
  logic [6:0] wr_peak;

  int n_checks = 0;
  int n_pass   = 0;

  wr_rd_ptr_sync_status #(
    .ADDR_WIDTH (6),
    .SYNC_STAGES(2),
    .AF_THRESH  (60)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .rd_ptr       (rd_ptr),
    .wr_ptr       (wr_ptr),
    .wr_en        (wr_en),
    .full         (full),
    .err_clr      (err_clr),
    .rd_sync_to_wr(rd_sync_to_wr),
    .wr_level     (wr_level),
    .almost_full  (almost_full),
    .level_valid  (level_valid),
    .overflow_err (overflow_err),
    .ptr_err      (ptr_err),
    .wr_peak      (wr_peak)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  initial begin
    wr_rst_n = 1'b0;
    rd_ptr   = 7'h00;
    wr_ptr   = 7'h00;
    wr_en    = 1'b0;
    full     = 1'b0;
    err_clr  = 1'b0;
    step(2);
    wr_rst_n = 1'b1;

    // 1: traffic, then asynchronous reset mid-cycle, then flush count
    rd_ptr = 7'h44;
    wr_ptr = 7'h07;
    step(6);
    check("pre_rst_level", wr_level, 32'd13);
    check("pre_rst_valid", level_valid, 32'd1);
    #3;
    wr_rst_n = 1'b0;
    #1;
    check("rst_level", wr_level, 32'd0);
    check("rst_valid", level_valid, 32'd0);
    check("rst_sync", rd_sync_to_wr, 32'd0);
    check("rst_af", almost_full, 32'd0);
    rd_ptr = 7'h00;
    wr_ptr = 7'h00;
    step(1);
    wr_rst_n = 1'b1;
    step(2);
    check("flush_2_valid", level_valid, 32'd0);
    step(1);
    check("flush_3_valid", level_valid, 32'd1);
    check("flush_3_level", wr_level, 32'd0);

    // 2: read pointer synchronizer latency
    wr_ptr = 7'h22;
    step(3);
    check("t2_level60", wr_level, 32'd60);
    check("t2_af1", almost_full, 32'd1);
    rd_ptr = 7'h01;
    step(1);
    check("t2_sync_e1", rd_sync_to_wr, 32'h00);
    step(1);
    check("t2_sync_e2", rd_sync_to_wr, 32'h01);
    check("t2_level_e2", wr_level, 32'd60);
    step(1);
    check("t2_level_e3", wr_level, 32'd59);
    check("t2_af_e3", almost_full, 32'd0);

    // 3: wr_ptr change visible after one edge; almost_full threshold
    rd_ptr = 7'h00;
    wr_ptr = 7'h22;
    step(4);
    check("t3_level60", wr_level, 32'd60);
    check("t3_af1", almost_full, 32'd1);
    wr_ptr = 7'h26;
    step(1);
    check("t3_level59", wr_level, 32'd59);
    check("t3_af0", almost_full, 32'd0);

    // 4: wrap-around and exactly-full level
    rd_ptr = 7'h44;
    wr_ptr = 7'h07;
    step(4);
    check("t4_level13", wr_level, 32'd13);
    check("t4_ptr_err0", ptr_err, 32'd0);
    wr_ptr = 7'h24;
    step(1);
    check("t4_level64", wr_level, 32'd64);
    check("t4_af_full", almost_full, 32'd1);
    step(1);
    check("t4_ptr_err_full", ptr_err, 32'd0);

    // 5: overflow_err sticky behaviour
    wr_en = 1'b1;
    full  = 1'b0;
    step(1);
    check("t5_no_ovf", overflow_err, 32'd0);
    full = 1'b1;
    step(1);
    wr_en = 1'b0;
    full  = 1'b0;
    check("t5_ovf_set", overflow_err, 32'd1);
    step(2);
    check("t5_ovf_hold", overflow_err, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_ovf_clr", overflow_err, 32'd0);
    wr_en   = 1'b1;
    full    = 1'b1;
    err_clr = 1'b1;
    step(1);
    wr_en   = 1'b0;
    full    = 1'b0;
    err_clr = 1'b0;
    check("t5_set_wins", overflow_err, 32'd1);
    step(1);
    check("t5_set_wins_hold", overflow_err, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_ovf_clr2", overflow_err, 32'd0);

    // 6: illegal level sets ptr_err; peak tracking and clear
    rd_ptr = 7'h00;
    wr_ptr = 7'h78;
    step(4);
    check("t6_level80", wr_level, 32'd80);
    check("t6_ptr_err1", ptr_err, 32'd1);
`ifdef WR_STATUS_PEAK_EN
    check("t6_peak80", wr_peak, 32'd80);
`else
    check("t6_peak_tied", wr_peak, 32'd0);
`endif
    wr_ptr = 7'h22;
    step(1);
    check("t6_level_legal", wr_level, 32'd60);
    check("t6_ptr_err_hold", ptr_err, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t6_ptr_err_clr", ptr_err, 32'd0);
`ifdef WR_STATUS_PEAK_EN
    check("t6_peak_clr", wr_peak, 32'd0);
    step(1);
    check("t6_peak_regrow", wr_peak, 32'd60);
`else
    step(1);
    check("t6_peak_tied2", wr_peak, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
